// File: rtl/bus_cycle_responder_if.sv
// 68030 asynchronous bus cycle signals seen by the slave-side responder.
interface bus_cycle_responder_if;
  logic       as;
  logic       rom_cs;
  logic       ram_cs;
  logic       io_cs;
  logic       io_ready;
  logic [1:0] dsack;
  logic       berr;
  logic       cycle_active;

  modport master (
    output as, rom_cs, ram_cs, io_cs, io_ready,
    input  dsack, berr, cycle_active
  );

  modport slave (
    input  as, rom_cs, ram_cs, io_cs, io_ready,
    output dsack, berr, cycle_active
  );
endinterface

// File: rtl/bus_cycle_responder.sv
// Ends 68030 bus cycles with DSACK after a per-region wait, or BERR after a timeout.
// All outputs registered; dsack asserts after edge E0+W+1, holds until AS is sampled high.
module bus_cycle_responder #(
  parameter int unsigned ROM_WAIT      = 3,
  parameter int unsigned RAM_WAIT      = 1,
  parameter int unsigned IO_WAIT       = 6,
  parameter logic [1:0]  ROM_DSACK     = 2'b00,
  parameter logic [1:0]  RAM_DSACK     = 2'b00,
  parameter logic [1:0]  IO_DSACK      = 2'b10,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  bus_cycle_responder_if.slave bus
);

  localparam int TW = TIMEOUT_WIDTH;
  localparam logic [TW-1:0] ROM_W   = TW'(ROM_WAIT);
  localparam logic [TW-1:0] RAM_W   = TW'(RAM_WAIT);
  localparam logic [TW-1:0] IO_W    = TW'(IO_WAIT);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = '1;
  localparam logic [TW-1:0] ONE     = TW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BERR} state_t;
  typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM, RG_IO} region_t;

  state_t        state, state_n;
  region_t       region, region_n;
  logic [TW-1:0] wait_cnt, wait_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          last_as;
  logic [1:0]    dsack_q, dsack_n;
  logic          berr_q, berr_n;
  logic          active_q, active_n;
  logic          ack_now;
  logic [1:0]    region_code;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      region   <= RG_NONE;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      last_as  <= 1'b1;
      dsack_q  <= 2'b11;
      berr_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state    <= state_n;
      region   <= region_n;
      wait_cnt <= wait_n;
      tmo_cnt  <= tmo_n;
      last_as  <= bus.as;
      dsack_q  <= dsack_n;
      berr_q   <= berr_n;
      active_q <= active_n;
    end
  end

  always_comb begin
    region_code = 2'b11;
    case (region)
      RG_ROM:  region_code = ROM_DSACK;
      RG_RAM:  region_code = RAM_DSACK;
      RG_IO:   region_code = IO_DSACK;
      default: region_code = 2'b11;
    endcase
  end

  always_comb begin
    state_n  = state;
    region_n = region;
    wait_n   = wait_cnt;
    tmo_n    = tmo_cnt;
    dsack_n  = dsack_q;
    berr_n   = berr_q;
    active_n = active_q;
    ack_now  = 1'b0;

    case (state)
      ST_IDLE: begin
        // Only a falling edge of AS starts a cycle; chip selects are captured here only.
        if (!bus.as && last_as) begin
          state_n  = ST_WAIT;
          active_n = 1'b1;
          tmo_n    = '0;
          if (bus.rom_cs) begin
            region_n = RG_ROM;
            wait_n   = ROM_W;
          end else if (bus.ram_cs) begin
            region_n = RG_RAM;
            wait_n   = RAM_W;
          end else if (bus.io_cs) begin
            region_n = RG_IO;
            wait_n   = IO_W;
          end else begin
            region_n = RG_NONE;
            wait_n   = '0;
          end
        end
      end

      ST_WAIT: begin
        if (bus.as) begin
          state_n  = ST_IDLE;
          active_n = 1'b0;
        end else begin
          if (tmo_cnt != TMO_MAX) tmo_n = tmo_cnt + ONE;
          if (wait_cnt != '0) begin
            wait_n = wait_cnt - ONE;
          end else if (region == RG_ROM || region == RG_RAM ||
                       (region == RG_IO && bus.io_ready)) begin
            ack_now = 1'b1;
          end
          // An acknowledge on the timeout edge takes precedence over the bus error.
          if (ack_now) begin
            state_n = ST_ACK;
            dsack_n = region_code;
          end else if (tmo_n >= TMO_LIM) begin
            state_n = ST_BERR;
            berr_n  = 1'b0;
          end
        end
      end

      default: begin
        if (bus.as) begin
          state_n  = ST_IDLE;
          dsack_n  = 2'b11;
          berr_n   = 1'b1;
          active_n = 1'b0;
        end
      end
    endcase
  end

  assign bus.dsack        = dsack_q;
  assign bus.berr         = berr_q;
  assign bus.cycle_active = active_q;

endmodule

// File: tb/tb_bus_cycle_responder.sv
// Drives two responders (timeout 255 and 8) with directed and random bus cycles against a cycle-count model.
module tb_bus_cycle_responder;

  localparam int P_IDLE = 0, P_WAIT = 1, P_ACK = 2, P_BERR = 3;
  localparam int R_NONE = 0, R_ROM = 1, R_RAM = 2, R_IO = 3;

  typedef struct {
    int ph;
    int e0;
    int rg;
    bit last_as;
  } mdl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic as_s = 1'b1, rom_s = 1'b0, ram_s = 1'b0, io_s = 1'b0, rdy_s = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  mdl_t ma, mb;

  always #5 clock = ~clock;

  bus_cycle_responder_if bus_a ();
  bus_cycle_responder_if bus_b ();

  assign bus_a.as = as_s;
  assign bus_a.rom_cs = rom_s;
  assign bus_a.ram_cs = ram_s;
  assign bus_a.io_cs = io_s;
  assign bus_a.io_ready = rdy_s;
  assign bus_b.as = as_s;
  assign bus_b.rom_cs = rom_s;
  assign bus_b.ram_cs = ram_s;
  assign bus_b.io_cs = io_s;
  assign bus_b.io_ready = rdy_s;

  bus_cycle_responder dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  bus_cycle_responder #(.TIMEOUT(8)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  function automatic int wait_of(int rg);
    case (rg)
      R_ROM:   return 3;
      R_RAM:   return 1;
      R_IO:    return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] code_of(int rg);
    return (rg == R_IO) ? 2'b10 : 2'b00;
  endfunction

  // Cycle-level rules: acknowledge no earlier than W+1 edges after start, error after tmo edges.
  function automatic mdl_t mstep(mdl_t m, int tmo, int n, bit rst, bit as,
                                 bit rom, bit ram, bit io, bit rdy);
    mdl_t r;
    int el;
    r = m;
    if (rst) begin
      r.ph = P_IDLE;
      r.last_as = 1'b1;
      return r;
    end
    case (m.ph)
      P_IDLE: if (!as && m.last_as) begin
        r.ph = P_WAIT;
        r.e0 = n;
        r.rg = rom ? R_ROM : ram ? R_RAM : io ? R_IO : R_NONE;
      end
      P_WAIT: begin
        if (as) r.ph = P_IDLE;
        else begin
          el = n - m.e0;
          if (m.rg != R_NONE && el >= wait_of(m.rg) + 1 && (m.rg != R_IO || rdy))
            r.ph = P_ACK;
          else if (el >= tmo)
            r.ph = P_BERR;
        end
      end
      default: if (as) r.ph = P_IDLE;
    endcase
    r.last_as = as;
    return r;
  endfunction

  function automatic logic [1:0] exp_dsack(mdl_t m);
    return (m.ph == P_ACK) ? code_of(m.rg) : 2'b11;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic step(int k = 1);
    repeat (k) @(negedge clock);
  endtask

  initial begin
    ma = '{P_IDLE, 0, R_NONE, 1'b1};
    mb = '{P_IDLE, 0, R_NONE, 1'b1};
  end

  always @(posedge clock) begin
    ma = mstep(ma, 255, cyc, reset, as_s, rom_s, ram_s, io_s, rdy_s);
    mb = mstep(mb, 8, cyc, reset, as_s, rom_s, ram_s, io_s, rdy_s);
    cyc++;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_dsack", bus_a.dsack, exp_dsack(ma));
      chk("a_berr", bus_a.berr, (ma.ph == P_BERR) ? 1'b0 : 1'b1);
      chk("a_active", bus_a.cycle_active, (ma.ph != P_IDLE) ? 1'b1 : 1'b0);
      chk("b_dsack", bus_b.dsack, exp_dsack(mb));
      chk("b_berr", bus_b.berr, (mb.ph == P_BERR) ? 1'b0 : 1'b1);
      chk("b_active", bus_b.cycle_active, (mb.ph != P_IDLE) ? 1'b1 : 1'b0);
    end
  end

  initial begin
    step();
    chk_en = 1'b1;
    chk("reset_dsack", bus_a.dsack, 2'b11);
    chk("reset_berr", bus_a.berr, 1'b1);
    chk("reset_active", bus_a.cycle_active, 1'b0);
    reset = 1'b0;
    step(2);

    // RAM cycle: ack after E0+2, release on AS high
    as_s = 1'b0; ram_s = 1'b1;
    step();
    chk("ram_e0_active", bus_a.cycle_active, 1'b1);
    step();
    chk("ram_e1_dsack", bus_a.dsack, 2'b11);
    step();
    chk("ram_e2_dsack", bus_a.dsack, 2'b00);
    as_s = 1'b1; ram_s = 1'b0;
    step();
    chk("ram_rel_dsack", bus_a.dsack, 2'b11);
    chk("ram_rel_active", bus_a.cycle_active, 1'b0);

    // IO cycle back-to-back, io_ready low for 10 edges
    as_s = 1'b0; io_s = 1'b1; rdy_s = 1'b0;
    step(10);
    chk("io_wait_dsack", bus_a.dsack, 2'b11);
    rdy_s = 1'b1;
    step();
    chk("io_rdy_dsack", bus_a.dsack, 2'b10);
    as_s = 1'b1;
    step();

    // IO with io_ready already high: not before E0+7
    as_s = 1'b0;
    step(7);
    chk("io_e6_dsack", bus_a.dsack, 2'b11);
    step();
    chk("io_e7_dsack", bus_a.dsack, 2'b10);
    as_s = 1'b1; io_s = 1'b0; rdy_s = 1'b0;
    step(2);

    // Unmapped cycle: berr exactly after E0+255
    as_s = 1'b0;
    step(255);
    chk("unm_e254_berr", bus_a.berr, 1'b1);
    step();
    chk("unm_e255_berr", bus_a.berr, 1'b0);
    chk("unm_e255_dsack", bus_a.dsack, 2'b11);
    as_s = 1'b1;
    step();
    chk("unm_rel_berr", bus_a.berr, 1'b1);

    // Abort a ROM cycle at E0+2, then a normal RAM cycle
    as_s = 1'b0; rom_s = 1'b1;
    step(2);
    as_s = 1'b1; rom_s = 1'b0;
    step();
    chk("abort_active", bus_a.cycle_active, 1'b0);
    step(4);
    chk("abort_dsack", bus_a.dsack, 2'b11);
    as_s = 1'b0; ram_s = 1'b1;
    step(3);
    chk("post_abort_dsack", bus_a.dsack, 2'b00);

    // Reset during ACK with AS held low
    reset = 1'b1;
    step();
    chk("rst_ack_dsack", bus_a.dsack, 2'b11);
    chk("rst_ack_berr", bus_a.berr, 1'b1);
    chk("rst_ack_active", bus_a.cycle_active, 1'b0);
    reset = 1'b0;
    step();
    chk("rst_restart_active", bus_a.cycle_active, 1'b1);
    step(2);
    chk("rst_restart_dsack", bus_a.dsack, 2'b00);
    as_s = 1'b1; ram_s = 1'b0;
    step(2);

    // io_ready arrives on the timeout edge of the short-timeout responder
    as_s = 1'b0; io_s = 1'b1; rdy_s = 1'b0;
    step(8);
    chk("sim_e7_berr", bus_b.berr, 1'b1);
    rdy_s = 1'b1;
    step();
    chk("sim_e8_dsack", bus_b.dsack, 2'b10);
    chk("sim_e8_berr", bus_b.berr, 1'b1);
    as_s = 1'b1; io_s = 1'b0; rdy_s = 1'b0;
    step(2);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (as_s) as_s = ($urandom_range(0, 2) != 0);
      else      as_s = ($urandom_range(0, 11) == 0);
      rom_s = ($urandom_range(0, 3) == 0);
      ram_s = ($urandom_range(0, 3) == 0);
      io_s  = ($urandom_range(0, 3) == 0);
      rdy_s = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
